// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: load funct3 codes, size decode and FSM states shared by the load align unit.
package load_align_unit_pkg;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011;
   localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, LWU = 3'b110;
   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;
   function automatic logic [3:0] load_size(input logic [2:0] funct3);
      return 4'd1 << funct3[1:0];
   endfunction
   function automatic logic load_legal(input logic [2:0] funct3, input int dwidth);
      return funct3 inside {LB, LH, LW, LBU, LHU} || (dwidth == 64 && funct3 inside {LD, LWU});
   endfunction
endpackage

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: request, memory and response signals of the load align unit.
interface load_align_unit_if #(parameter int DWIDTH = 32, parameter int AWIDTH = 32);
   localparam int WAW = AWIDTH - $clog2(DWIDTH / 8);
   logic              req_valid;
   logic              req_ready;
   logic [AWIDTH-1:0] req_addr;
   logic [2:0]        req_funct3;
   logic              mem_re;
   logic [WAW-1:0]    mem_addr;
   logic [DWIDTH-1:0] mem_rdata;
   logic              resp_valid;
   logic [DWIDTH-1:0] resp_data;
   logic              resp_fault;
   modport master(output req_valid, req_addr, req_funct3, mem_rdata,
                  input req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_fault);
   modport slave(input req_valid, req_addr, req_funct3, mem_rdata,
                 output req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_fault);
endinterface

// File: rtl/load_byte_extract.sv
// load_byte_extract: selects the little-endian byte lanes of a load and sign/zero extends them.
module load_byte_extract
   import load_align_unit_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int OW     = $clog2(DWIDTH / 8)
) (
   input  logic [DWIDTH-1:0] word,
   input  logic [OW-1:0]     off,
   input  logic [2:0]        funct3,
   output logic [DWIDTH-1:0] data
);
   localparam int NB = DWIDTH / 8;
   logic [DWIDTH-1:0] sh;
   int                nb;
   logic              sgn;
   always_comb begin
      sh  = word >> {off, 3'b000};
      nb  = int'(load_size(funct3));
      nb  = nb > NB ? NB : nb;
      sgn = !funct3[2] && sh[nb*8-1];
      data = '0;
      for (int i = 0; i < NB; i++) data[i*8 +: 8] = i < nb ? sh[i*8 +: 8] : {8{sgn}};
   end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: issues one or two word reads per load, merges lanes across the word
// boundary and returns a registered, extended response with a fault flag.
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input logic clk,
   input logic rst,
   load_align_unit_if.slave bus
);
   localparam int NB  = DWIDTH / 8;
   localparam int OW  = $clog2(NB);
   localparam int WAW = AWIDTH - OW;
   state_t            state, state_d;
   logic [OW-1:0]     off_q, off_in, ext_off;
   logic [2:0]        f3_q;
   logic [WAW-1:0]    wa_q;
   logic              cross_q, cross_in, fault_in, accept, done;
   logic [DWIDTH-1:0] hi_q, merged, ext_word, ext;
   always_comb begin
      off_in   = bus.req_addr[OW-1:0];
      accept   = bus.req_valid && state == IDLE;
      cross_in = int'(off_in) + int'(load_size(bus.req_funct3)) > NB;
      fault_in = !load_legal(bus.req_funct3, DWIDTH) || (cross_in && !MISALIGN_EN);
      done     = (state == FIRST && !cross_q) || state == SECOND;
      // hi_q already holds word W shifted down, so W+1 lands right above its bytes
      merged   = hi_q | (bus.mem_rdata << (DWIDTH - 8 * int'(off_q)));
      ext_word = state == SECOND ? merged : bus.mem_rdata;
      ext_off  = state == SECOND ? {OW{1'b0}} : off_q;
      bus.req_ready = state == IDLE;
      bus.mem_re    = (accept && !fault_in) || (state == FIRST && cross_q);
      bus.mem_addr  = !bus.mem_re ? '0 : state == FIRST ? wa_q + 1'b1 : bus.req_addr[AWIDTH-1:OW];
      state_d = state == IDLE ? (accept && !fault_in ? FIRST : IDLE) :
                state == FIRST && cross_q ? SECOND : IDLE;
   end
   load_byte_extract #(.DWIDTH(DWIDTH)) u_extract (
      .word(ext_word),
      .off(ext_off),
      .funct3(f3_q),
      .data(ext)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_d;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         off_q          <= '0;
         f3_q           <= '0;
         wa_q           <= '0;
         cross_q        <= 1'b0;
         hi_q           <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_fault <= 1'b0;
         bus.resp_data  <= '0;
      end else begin
         bus.resp_valid <= (accept && fault_in) || done;
         if (accept) begin
            off_q   <= off_in;
            f3_q    <= bus.req_funct3;
            wa_q    <= bus.req_addr[AWIDTH-1:OW];
            cross_q <= cross_in;
         end
         if (accept && fault_in) begin
            bus.resp_fault <= 1'b1;
            bus.resp_data  <= '0;
         end
         if (done) begin
            bus.resp_fault <= 1'b0;
            bus.resp_data  <= ext;
         end
         if (state == FIRST && cross_q) hi_q <= bus.mem_rdata >> {off_q, 3'b000};
      end
   end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed loads against 32-bit (misalign on/off) and 64-bit instances.
module tb_load_align_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   load_align_unit_if #(.DWIDTH(32), .AWIDTH(32)) b0 ();
   load_align_unit_if #(.DWIDTH(32), .AWIDTH(32)) b1 ();
   load_align_unit_if #(.DWIDTH(64), .AWIDTH(32)) b2 ();
   load_align_unit #(.DWIDTH(32), .AWIDTH(32), .MISALIGN_EN(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   load_align_unit #(.DWIDTH(32), .AWIDTH(32), .MISALIGN_EN(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   load_align_unit #(.DWIDTH(64), .AWIDTH(32), .MISALIGN_EN(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
   logic [31:0] m32[int];
   logic [63:0] m64[int];
   function automatic logic [31:0] rd32(input int a);
      return m32.exists(a) ? m32[a] : 32'h0;
   endfunction
   function automatic logic [63:0] rd64(input int a);
      return m64.exists(a) ? m64[a] : 64'h0;
   endfunction
   always @(posedge clk) begin
      if (b0.mem_re) b0.mem_rdata <= rd32(int'(b0.mem_addr));
      if (b1.mem_re) b1.mem_rdata <= rd32(int'(b1.mem_addr));
      if (b2.mem_re) b2.mem_rdata <= rd64(int'(b2.mem_addr));
   end
   int          rd_n[3];
   int          rd_c[3][64];
   logic [63:0] rd_a[3][64];
   int          rs_n[3];
   int          rs_c[3][64];
   logic [63:0] rs_d[3][64];
   logic        rs_f[3][64];
   task automatic log_dut(input int n, input logic re, input logic [63:0] a, input logic v,
                          input logic [63:0] d, input logic f);
      if (re) begin
         if (rd_n[n] < 64) begin
            rd_c[n][rd_n[n]] = cyc;
            rd_a[n][rd_n[n]] = a;
         end
         rd_n[n]++;
      end
      if (v) begin
         if (rs_n[n] < 64) begin
            rs_c[n][rs_n[n]] = cyc;
            rs_d[n][rs_n[n]] = d;
            rs_f[n][rs_n[n]] = f;
         end
         rs_n[n]++;
      end
   endtask
   always @(negedge clk) begin
      log_dut(0, b0.mem_re, 64'(b0.mem_addr), b0.resp_valid, 64'(b0.resp_data), b0.resp_fault);
      log_dut(1, b1.mem_re, 64'(b1.mem_addr), b1.resp_valid, 64'(b1.resp_data), b1.resp_fault);
      log_dut(2, b2.mem_re, 64'(b2.mem_addr), b2.resp_valid, b2.resp_data, b2.resp_fault);
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic chk_resp(input string tag, input int n, input int k, input int c,
                           input logic [63:0] d, input logic f);
      chk({tag, ".cyc"}, 64'(rs_c[n][k]), 64'(c));
      chk({tag, ".data"}, rs_d[n][k], d);
      chk({tag, ".fault"}, 64'(rs_f[n][k]), 64'(f));
   endtask
   task automatic issue(input int n, input logic [31:0] a, input logic [2:0] f, output int t);
      @(posedge clk);
      #2;
      b0.req_addr = a;
      b1.req_addr = a;
      b2.req_addr = a;
      b0.req_funct3 = f;
      b1.req_funct3 = f;
      b2.req_funct3 = f;
      b0.req_valid = n == 0;
      b1.req_valid = n == 1;
      b2.req_valid = n == 2;
      t = cyc;
      chk($sformatf("ready%0d", n), 64'(n == 0 ? b0.req_ready : n == 1 ? b1.req_ready : b2.req_ready), 64'd1);
      @(posedge clk);
      #2;
      b0.req_valid = 1'b0;
      b1.req_valid = 1'b0;
      b2.req_valid = 1'b0;
   endtask
   task automatic idle(input int k);
      repeat (k) @(posedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int t, t2, t3, r, s;
      b0.req_valid = 1'b0;
      b1.req_valid = 1'b0;
      b2.req_valid = 1'b0;
      b0.req_addr = '0;
      b1.req_addr = '0;
      b2.req_addr = '0;
      b0.req_funct3 = '0;
      b1.req_funct3 = '0;
      b2.req_funct3 = '0;
      m32[32'h400] = 32'h80FF_1234;
      m32[32'h800] = 32'hBEEF_0000;
      m32[32'hC00] = 32'h4433_2211;
      m32[32'hC01] = 32'h8877_6655;
      m64[32'h200] = 64'hF000_0001_0000_0000;
      m64[32'h1FFF_FFFF] = 64'h8877_6655_4433_2211;
      m64[32'h0] = 64'h00FF_EEDD_CCBB_AA99;
      idle(3);
      @(negedge clk);
      chk("rst.ready", 64'(b0.req_ready), 64'd1);
      chk("rst.valid", 64'(b0.resp_valid), 64'd0);
      chk("rst.fault", 64'(b0.resp_fault), 64'd0);
      chk("rst.data", 64'(b0.resp_data), 64'd0);
      chk("rst.re", 64'(b0.mem_re), 64'd0);
      chk("rst.addr", 64'(b0.mem_addr), 64'd0);
      chk("rst.data64", b2.resp_data, 64'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      r = rd_n[0]; s = rs_n[0];
      issue(0, 32'h1003, 3'b000, t);
      idle(4);
      chk("lb.rd_n", 64'(rd_n[0] - r), 64'd1);
      chk("lb.rd_cyc", 64'(rd_c[0][r]), 64'(t));
      chk("lb.rd_addr", rd_a[0][r], 64'h400);
      chk("lb.rs_n", 64'(rs_n[0] - s), 64'd1);
      chk_resp("lb", 0, s, t + 2, 64'hFFFF_FF80, 1'b0);
      s = rs_n[0];
      issue(0, 32'h2002, 3'b101, t);
      idle(4);
      chk_resp("lhu", 0, s, t + 2, 64'h0000_BEEF, 1'b0);
      s = rs_n[0];
      issue(0, 32'h2002, 3'b001, t);
      idle(4);
      chk_resp("lh", 0, s, t + 2, 64'hFFFF_BEEF, 1'b0);
      r = rd_n[0]; s = rs_n[0];
      issue(0, 32'h3001, 3'b010, t);
      idle(5);
      chk("lwmis.rd_n", 64'(rd_n[0] - r), 64'd2);
      chk("lwmis.rd0_cyc", 64'(rd_c[0][r]), 64'(t));
      chk("lwmis.rd0_addr", rd_a[0][r], 64'hC00);
      chk("lwmis.rd1_cyc", 64'(rd_c[0][r+1]), 64'(t + 1));
      chk("lwmis.rd1_addr", rd_a[0][r+1], 64'hC01);
      chk("lwmis.rs_n", 64'(rs_n[0] - s), 64'd1);
      chk_resp("lwmis", 0, s, t + 3, 64'h5544_3322, 1'b0);
      r = rd_n[1]; s = rs_n[1];
      issue(1, 32'h0003, 3'b001, t);
      idle(4);
      chk("nomis.rd_n", 64'(rd_n[1] - r), 64'd0);
      chk("nomis.rs_n", 64'(rs_n[1] - s), 64'd1);
      chk_resp("nomis", 1, s, t + 1, 64'h0, 1'b1);
      r = rd_n[1]; s = rs_n[1];
      issue(1, 32'h1000, 3'b010, t);
      idle(4);
      chk("nomis_lw.rd_n", 64'(rd_n[1] - r), 64'd1);
      chk_resp("nomis_lw", 1, s, t + 2, 64'h80FF_1234, 1'b0);
      r = rd_n[0]; s = rs_n[0];
      issue(0, 32'h1000, 3'b011, t);
      idle(4);
      chk("ld32.rd_n", 64'(rd_n[0] - r), 64'd0);
      chk_resp("ld32", 0, s, t + 1, 64'h0, 1'b1);
      s = rs_n[0];
      issue(0, 32'h1000, 3'b111, t);
      idle(4);
      chk_resp("f3_111", 0, s, t + 1, 64'h0, 1'b1);
      r = rd_n[2]; s = rs_n[2];
      issue(2, 32'h1004, 3'b110, t);
      idle(4);
      chk("lwu64.rd_addr", rd_a[2][r], 64'h200);
      chk_resp("lwu64", 2, s, t + 2, 64'h0000_0000_F000_0001, 1'b0);
      s = rs_n[2];
      issue(2, 32'h1004, 3'b010, t);
      idle(4);
      chk_resp("lw64", 2, s, t + 2, 64'hFFFF_FFFF_F000_0001, 1'b0);
      r = rd_n[2]; s = rs_n[2];
      issue(2, 32'hFFFF_FFFC, 3'b011, t);
      idle(5);
      chk("wrap.rd_n", 64'(rd_n[2] - r), 64'd2);
      chk("wrap.rd0_addr", rd_a[2][r], 64'h1FFF_FFFF);
      chk("wrap.rd1_addr", rd_a[2][r+1], 64'h0);
      chk("wrap.rd1_cyc", 64'(rd_c[2][r+1]), 64'(t + 1));
      chk_resp("wrap", 2, s, t + 3, 64'hCCBB_AA99_8877_6655, 1'b0);
      r = rd_n[0]; s = rs_n[0];
      issue(0, 32'h3001, 3'b010, t);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      chk("rst2.ready", 64'(b0.req_ready), 64'd1);
      chk("rst2.valid", 64'(b0.resp_valid), 64'd0);
      idle(4);
      chk("rst2.rd_n", 64'(rd_n[0] - r), 64'd2);
      chk("rst2.rs_n", 64'(rs_n[0] - s), 64'd0);
      s = rs_n[0];
      issue(0, 32'h1003, 3'b000, t);
      issue(0, 32'h2002, 3'b101, t2);
      issue(0, 32'h1000, 3'b010, t3);
      idle(4);
      chk("b2b.gap1", 64'(t2 - t), 64'd2);
      chk("b2b.gap2", 64'(t3 - t2), 64'd2);
      chk("b2b.rs_n", 64'(rs_n[0] - s), 64'd3);
      chk_resp("b2b0", 0, s, t + 2, 64'hFFFF_FF80, 1'b0);
      chk_resp("b2b1", 0, s + 1, t2 + 2, 64'h0000_BEEF, 1'b0);
      chk_resp("b2b2", 0, s + 2, t3 + 2, 64'h80FF_1234, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential load-data path between the LSU address stage and a synchronous data memory with 1-cycle read latency.
- Accepts a load request (byte address, funct3) and issues one or two word reads. Accesses that cross a word boundary take two reads.
- Merges the byte lanes, then sign- or zero-extends the result.
- Returns a registered response with a fault flag. It generalises the combinational load extension to 32/64-bit data paths and adds misaligned-access support.

Parameters:
- DWIDTH, 32, memory word and result width; legal values 32 or 64.
- AWIDTH, 32, byte-address width.
- MISALIGN_EN, 1, controls misaligned loads. 1: split into two reads. 0: return a fault with no memory read.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  load request valid
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_addr  input  AWIDTH  byte address
- req_funct3  input  3  load type
- mem_re  output  1  memory read enable
- mem_addr  output  AWIDTH-log2(DWIDTH/8)  word address
- mem_rdata  input  DWIDTH  read data, valid the cycle after mem_re
- resp_valid  output  1  one-cycle response pulse; no backpressure
- resp_data  output  DWIDTH  extended load result; 0 when resp_fault=1
- resp_fault  output  1  misaligned (MISALIGN_EN=0) or illegal funct3

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE; req_ready=1 (IDLE).
  - resp_valid=0, resp_fault=0, resp_data=0.
  - mem_re=0, mem_addr=0.
- Reset mid-operation: any state returns to IDLE and the pending response is discarded. mem_rdata in the following cycle is ignored.
- funct3 encoding:
  - LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - LD=011 and LWU=110 are legal only when DWIDTH=64.
  - Every other code is illegal.
- Size: 1, 2, 4 or 8 bytes. off = req_addr[log2(DWIDTH/8)-1:0]. Little-endian byte lanes.
- Crossing condition: crossing = off + size > DWIDTH/8.
- Handshake: a request is accepted when req_valid && req_ready. The request is latched (off, funct3, word address W).
- State IDLE, on accept:
  - Illegal funct3, or crossing with MISALIGN_EN=0: no read. Register resp_valid=1, resp_fault=1, resp_data=0, visible next cycle. Stay in IDLE.
  - Otherwise: mem_re=1 and mem_addr=W, combinational in the acceptance cycle T. Go to FIRST.
- State FIRST:
  - mem_rdata holds word W.
  - If not crossing: extract bytes off..off+size-1 and extend. Register the result; resp_valid=1 at T+2. Go to IDLE.
  - If crossing: latch the upper bytes of word W (lanes off..top). Drive mem_re=1, mem_addr=W+1. Go to SECOND.
  - Word address W+1 wraps modulo 2^(AWIDTH-log2(DWIDTH/8)).
- State SECOND:
  - mem_rdata holds word W+1.
  - Low bytes of word W+1 supply the remaining size-(bytes from W) bytes.
  - Merge as {W+1 low bytes, W high bytes}, extend and register. resp_valid=1 at T+3. Go to IDLE.
- Extension: signed types replicate the MSB of the loaded value to DWIDTH; unsigned types zero-fill. LW at DWIDTH=32 and LD at DWIDTH=64 pass through.
- resp_valid is high for exactly one cycle per accepted request. resp_data and resp_fault hold until the next response.
- Throughput: a request may be accepted in the same cycle resp_valid is high (the unit is in IDLE then). Peak rate is one aligned load per 2 cycles.
- mem_re is 0 in all cycles other than those specified above.

Decomposition:
- Shared package (riscv_pkg / opcode constants file) holds:
  - funct3 load localparams LB..LWU;
  - size-decode function;
  - FSM state encodings IDLE/FIRST/SECOND.
- One combinational sub-module, load_byte_extract: a (DWIDTH-bit word, offset, funct3) lane selector and extender, reused for the aligned path and the merged misaligned word.
- The top holds the FSM, request latch and merge register.

Test Plan:
- Aligned LB, DWIDTH=32: addr=0x1003, word at 0x400 = 0x80FF_1234 -> mem_addr=0x400 at T; resp_valid at T+2; resp_data=0xFFFF_FF80, fault=0.
- LHU at addr=0x2002, word=0xBEEF_0000 -> resp_data=0x0000_BEEF at T+2. Same request as LH -> 0xFFFF_BEEF.
- Misaligned LW, MISALIGN_EN=1: addr=0x3001, words [0xC00]=0x4433_2211 and [0xC01]=0x8877_6655 -> reads 0xC00 at T and 0xC01 at T+1; resp_data=0x5544_3322 at T+3.
- Misaligned LH, MISALIGN_EN=0: addr=0x0003 -> mem_re never asserted; resp_valid at T+1 with fault=1, data=0. Same for funct3=011 at DWIDTH=32.
- DWIDTH=64 LWU: addr=0x1004, word=0xF000_0001_0000_0000 -> 0x0000_0000_F000_0001. Wrap case: LD at top word, W+1 = 0.
- rst asserted in SECOND -> next cycle IDLE, req_ready=1, no resp_valid. Back-to-back aligned loads are accepted every 2 cycles with correct data.
